s_memory_reader: RTL and testbench
==================================

// Module: s_memory_reader
// PURPOSE
//  Reader side of the 256x8 S-memory port: the initializer writes it, this block reads it back.
//  - On start, sweeps addresses START_ADDR..END_ADDR and issues one read per cycle while space allows.
//  - Compensates the RAM's synchronous read latency and streams each byte to a consumer over valid/ready.
//  - Sits between s_memory and the key-schedule / debug logic, which apply backpressure.
// PARAMETERS
//  ADDR_W      8    memory address width
//  DATA_W      8    memory data width
//  RD_LATENCY  1    cycles from mem_address to valid mem_q (1..3)
//  FIFO_DEPTH  4    output buffer entries; must be >= RD_LATENCY+1, power of 2
//  START_ADDR  0    first address read
//  END_ADDR    255  last address read (>= START_ADDR)
// PORTS
//  clk          in   1       system clock, rising edge
//  reset_n      in   1       asynchronous active-low reset
//  start        in   1       1-cycle pulse; begins a sweep when idle
//  busy         out  1       high from accepted start until done
//  done         out  1       1-cycle pulse after the last byte is accepted downstream
//  mem_address  out  ADDR_W  read address to s_memory
//  mem_wren     out  1       tied 0; the reader never writes
//  mem_q        in   DATA_W  s_memory read data, valid RD_LATENCY cycles after its address
//  out_data     out  DATA_W  byte read
//  out_index    out  ADDR_W  address out_data came from
//  out_valid    out  1       out_data/out_index valid
//  out_ready    in   1       consumer accepts when out_valid && out_ready
//  perm_ok      out  1       (PERM_CHECK_EN only) sweep data formed a permutation
// BEHAVIOUR
//  - Reset (async, reset_n=0): FSM=IDLE; busy=0; done=0; out_valid=0; mem_address=START_ADDR;
//    out_data=0; out_index=0; FIFO empty; in-flight count 0; perm_ok=0.
//  - FSM states:
//    IDLE -start-> ISSUE
//    ISSUE -last address issued-> DRAIN
//    DRAIN -FIFO empty && in-flight==0-> DONE
//    DONE -> IDLE (1 cycle)
//  - start is ignored outside IDLE. busy=1 in ISSUE/DRAIN/DONE. done=1 only in DONE.
//  - Issue rule: in ISSUE, a read issues in a cycle iff fifo_count + inflight < FIFO_DEPTH.
//    Issuing a read advances mem_address next cycle. The FIFO therefore never overflows and
//    no returned data is dropped.
//  - Read tagging: each issued address enters a RD_LATENCY-deep valid/index shift pipe.
//    On pipe exit, {mem_q, index} is pushed into the FIFO.
//  - Output: out_* shows the FIFO head, first-word-fall-through.
//    Pop on out_valid && out_ready. Push and pop in the same cycle leave the count unchanged.
//  - Minimum start->first out_valid latency: 1 (IDLE->ISSUE) + RD_LATENCY + 1 (FIFO write) cycles.
//  - Throughput: 1 byte/cycle with out_ready held high.
//  - Order: out_index strictly increments START_ADDR..END_ADDR; no gaps, no duplicates.
//  - Counter arithmetic: the address counter is ADDR_W+1 bits, so END_ADDR=255 terminates
//    without wrapping to 0.
//  - out_ready low for any duration stalls issue once the FIFO plus in-flight reads reach
//    FIFO_DEPTH. Issue resumes on the first pop.
//  - A mid-sweep reset_n assertion aborts immediately to reset values. The next start runs
//    a complete fresh sweep.
// CONFIGURATION
//  - PERM_CHECK_EN defined:
//    - Adds a 2^DATA_W-bit seen mask, cleared on accepted start.
//    - Each popped byte sets seen[out_data].
//    - Sticky dup flag sets if that bit was already set.
//    - In DONE, perm_ok = !dup && (all seen bits set when the sweep covered the full range).
//    - perm_ok holds until the next start or reset.
//  - Not defined: no mask logic; perm_ok is tied 0.
// TESTING
//  1. Memory preloaded S[i]=i, out_ready=1, start:
//     out_data==out_index for 0..255, 256 contiguous beats, done pulses once, busy drops with done.
//  2. out_ready toggled pseudo-randomly (25% high):
//     every 0..255 delivered exactly once, in order; FIFO never overflows (assert).
//  3. RD_LATENCY=3, FIFO_DEPTH=4, out_ready=0 for 50 cycles after start:
//     at most 4 reads issued; after release, data==S[index] for all beats.
//  4. reset_n pulsed low at beat 100, then start again:
//     outputs at reset values immediately; second sweep starts at index 0 and completes 256 beats.
//  5. start pulsed while busy: ignored; exactly one done and 256 beats.
//  6. PERM_CHECK_EN, S = identity then S[7]=S[8]=9:
//     perm_ok=1 for the identity sweep; perm_ok=0 for the duplicate sweep.

Source files
------------

// File: rtl/s_memory_reader.sv
// s_memory_reader: reader side of the 256x8 S-memory port.
// On start, sweeps START_ADDR..END_ADDR and issues one read per cycle while
// there is room downstream. It tags each read with its address, absorbs the
// RAM's fixed read latency in a shift pipe, and streams {data, index} pairs
// through a small first-word-fall-through FIFO using valid/ready.
// Optional feature: define PERM_CHECK_EN to add a permutation checker that
// drives perm_ok. Without it, perm_ok is tied 0.
module s_memory_reader #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int START_ADDR = 0,
    parameter int END_ADDR   = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              perm_ok
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // The address counter is one bit wider than the address, so END_ADDR at
    // the top of the address space finishes without wrapping back to zero.
    localparam logic [ADDR_W:0]  FIRST_ADDR = (ADDR_W+1)'(START_ADDR);
    localparam logic [ADDR_W:0]  LAST_ADDR  = (ADDR_W+1)'(END_ADDR);
    localparam logic [SUM_W-1:0] DEPTH_S    = SUM_W'(FIFO_DEPTH);

    logic [1:0]        state, state_next;
    logic [ADDR_W:0]   addr_cnt;
    logic [RD_LATENCY-1:0] pipe_v;
    logic [ADDR_W-1:0] pipe_idx [RD_LATENCY];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_idx  [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  inflight;
    logic [SUM_W-1:0]  occupancy;
    logic              start_ok, issue, last_issue, push, pop, drained;

    // Count the reads that are still travelling through the latency pipe.
    always_comb begin
        // NOTE: assign a default before the loop so no path leaves the
        // variable unassigned; an unassigned path would infer a latch.
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CNT_W'(pipe_v[i]);
        end
    end

    // Handshake and issue qualifiers. A read issues only when buffered plus
    // outstanding entries leave room, so every returning byte has a slot.
    assign occupancy  = SUM_W'(fifo_count) + SUM_W'(inflight);
    assign start_ok   = (state == S_IDLE) && start;
    assign issue      = (state == S_ISSUE) && (occupancy < DEPTH_S);
    assign last_issue = issue && (addr_cnt == LAST_ADDR);
    assign push       = pipe_v[RD_LATENCY-1];
    assign out_valid  = (fifo_count != '0);
    assign pop        = out_valid && out_ready;
    assign drained    = (fifo_count == '0) && (inflight == '0);

    // Next-state logic for the sweep sequencer.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start)      state_next = S_ISSUE;
            S_ISSUE: if (last_issue) state_next = S_DRAIN;
            S_DRAIN: if (drained)    state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: non-blocking assignments make every flop update from
        // pre-edge values, whatever order the statements appear in.
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    // Address counter: rewinds on an accepted start and steps once per issued read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      addr_cnt <= FIRST_ADDR;
        else if (start_ok) addr_cnt <= FIRST_ADDR;
        else if (issue)    addr_cnt <= addr_cnt + (ADDR_W+1)'(1);
    end

    // Valid bits of the read-latency pipe; one stage per cycle of RAM latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_v <= '0;
        end else begin
            pipe_v[0] <= issue;
            for (int i = 1; i < RD_LATENCY; i++) pipe_v[i] <= pipe_v[i-1];
        end
    end

    // Index tags that travel alongside the valid bits.
    always_ff @(posedge clk) begin
        pipe_idx[0] <= mem_address;
        for (int i = 1; i < RD_LATENCY; i++) pipe_idx[i] <= pipe_idx[i-1];
    end

    // FIFO storage: the returned byte and its address, written as the read leaves the pipe.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; every read of it is
        // qualified by fifo_count, which is reset.
        if (push) begin
            fifo_data[wr_ptr] <= mem_q;
            fifo_idx[wr_ptr]  <= pipe_idx[RD_LATENCY-1];
        end
    end

    // FIFO pointers and occupancy. A push and a pop together leave the count unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // First-word-fall-through head. It is forced to zero when empty, so
    // outputs never show stale entries.
    assign out_data    = out_valid ? fifo_data[rd_ptr] : '0;
    assign out_index   = out_valid ? fifo_idx[rd_ptr]  : '0;
    assign mem_address = addr_cnt[ADDR_W-1:0];
    assign mem_wren    = 1'b0;
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);

`ifdef PERM_CHECK_EN
    localparam int SYMBOLS    = 2**DATA_W;
    localparam bit FULL_RANGE = ((END_ADDR - START_ADDR + 1) == SYMBOLS);

    logic [SYMBOLS-1:0] seen;
    logic               dup;
    logic               perm_q;

    // Mark each delivered byte and flag repeats. The verdict is latched as
    // DONE is entered and held until the next sweep starts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seen   <= '0;
            dup    <= 1'b0;
            perm_q <= 1'b0;
        end else if (start_ok) begin
            seen   <= '0;
            dup    <= 1'b0;
            perm_q <= 1'b0;
        end else begin
            if (pop) begin
                if (seen[out_data]) dup <= 1'b1;
                seen[out_data] <= 1'b1;
            end
            if ((state == S_DRAIN) && drained)
                perm_q <= !dup && (!FULL_RANGE || (&seen));
        end
    end

    assign perm_ok = perm_q;
`else
    assign perm_ok = 1'b0;
`endif

endmodule

// File: tb/tb_s_memory_reader.sv
// Directed bench for s_memory_reader. It uses a default instance (latency 1)
// and a second instance with RD_LATENCY=3 and FIFO_DEPTH=4. Each instance has
// its own synchronous RAM model, and both models share one S-memory array.
module tb_s_memory_reader;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0, out_ready = 1'b0;
    logic       busy, done, mem_wren, out_valid, perm_ok;
    logic [7:0] mem_address, mem_q, out_data, out_index;

    logic       start3 = 1'b0, out_ready3 = 1'b0;
    logic       busy3, done3, wren3, valid3, perm3;
    logic [7:0] addr3, q3, data3, idx3;

    logic [7:0] smem [256];
    logic [7:0] q3_p [3];

    int n_cmp = 0;
    int n_bad = 0;

    // Stats gathered by run1; the test tasks compare them.
    int beats, bad_beats, dones, first_c, last_c, done_c, busy_err, exp_idx;
    bit busy_at_done, busy_after_done, timed_out;

    always #5 clk = ~clk;

    s_memory_reader dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .mem_address(mem_address), .mem_wren(mem_wren), .mem_q(mem_q),
        .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
        .out_ready(out_ready), .perm_ok(perm_ok)
    );

    s_memory_reader #(.RD_LATENCY(3), .FIFO_DEPTH(4)) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start3), .busy(busy3), .done(done3),
        .mem_address(addr3), .mem_wren(wren3), .mem_q(q3),
        .out_data(data3), .out_index(idx3), .out_valid(valid3),
        .out_ready(out_ready3), .perm_ok(perm3)
    );

    // RAM models: latency 1 for dut, latency 3 for dut3.
    always @(posedge clk) mem_q <= smem[mem_address];
    always @(posedge clk) begin
        q3_p[0] <= smem[addr3];
        q3_p[1] <= q3_p[0];
        q3_p[2] <= q3_p[1];
    end
    assign q3 = q3_p[2];

    task automatic load_identity();
        for (int i = 0; i < 256; i++) smem[i] = 8'(i);
    endtask

    task automatic load_scramble();
        for (int i = 0; i < 256; i++) smem[i] = 8'((i * 37 + 11) % 256);
    endtask

    // Drive one sweep on dut and collect stats. A beat is counted at the
    // negedge where out_valid && out_ready hold, since it is accepted on the next edge.
    task automatic run1(input int ready_pct, input int stray_at, input int stop_beat,
                        input int budget);
        int c;
        bit fin;
        beats = 0; bad_beats = 0; dones = 0; first_c = -1; last_c = -1; done_c = -1;
        busy_err = 0; exp_idx = 0; busy_at_done = 0; busy_after_done = 1;
        timed_out = 0; fin = 0; c = 0;
        while (!fin) begin
            @(negedge clk);
            start = (c == 0) || (c == stray_at);
            out_ready = ($urandom_range(99) < ready_pct);
            if (done_c >= 0) begin
                busy_after_done = busy;
                fin = 1;
            end else begin
                if (c >= 1 && !busy) busy_err++;
                if (done) begin
                    dones++;
                    done_c = c;
                    busy_at_done = busy;
                end
            end
            if (!fin && out_valid && out_ready) begin
                if (out_index !== 8'(exp_idx) || out_data !== smem[exp_idx & 255]) bad_beats++;
                if (first_c < 0) first_c = c;
                last_c = c;
                beats++;
                exp_idx++;
                if (beats == stop_beat) fin = 1;
            end
            c++;
            if (!fin && c >= budget) begin
                timed_out = 1;
                fin = 1;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %0b want 0", done); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %0b want 0", out_valid); end
        n_cmp++; if (mem_address !== 8'd0) begin n_bad++; $display("FAIL rst_addr: got %0d want 0", mem_address); end
        n_cmp++; if (out_data !== 8'd0) begin n_bad++; $display("FAIL rst_data: got %0d want 0", out_data); end
        n_cmp++; if (out_index !== 8'd0) begin n_bad++; $display("FAIL rst_index: got %0d want 0", out_index); end
        n_cmp++; if (mem_wren !== 1'b0) begin n_bad++; $display("FAIL rst_wren: got %0b want 0", mem_wren); end
        n_cmp++; if (perm_ok !== 1'b0) begin n_bad++; $display("FAIL rst_perm: got %0b want 0", perm_ok); end
        @(negedge clk) reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_identity_stream();
        load_identity();
        run1(100, -1, -1, 2000);
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL id_timeout: got %0b want 0", timed_out); end
        n_cmp++; if (beats !== 256) begin n_bad++; $display("FAIL id_beats: got %0d want 256", beats); end
        n_cmp++; if (bad_beats !== 0) begin n_bad++; $display("FAIL id_data: got %0d bad beats want 0", bad_beats); end
        n_cmp++; if (first_c !== 3) begin n_bad++; $display("FAIL id_latency: got %0d want 3", first_c); end
        n_cmp++; if (last_c - first_c + 1 !== 256) begin n_bad++; $display("FAIL id_contiguous: got span %0d want 256", last_c - first_c + 1); end
        n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL id_done_count: got %0d want 1", dones); end
        n_cmp++; if (done_c <= last_c) begin n_bad++; $display("FAIL id_done_order: got done at %0d last beat %0d", done_c, last_c); end
        n_cmp++; if (busy_err !== 0) begin n_bad++; $display("FAIL id_busy_hold: got %0d low cycles want 0", busy_err); end
        n_cmp++; if (busy_at_done !== 1'b1) begin n_bad++; $display("FAIL id_busy_at_done: got %0b want 1", busy_at_done); end
        n_cmp++; if (busy_after_done !== 1'b0) begin n_bad++; $display("FAIL id_busy_drop: got %0b want 0", busy_after_done); end
    endtask

    task automatic test_random_backpressure();
        load_scramble();
        run1(25, -1, -1, 8000);
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL bp_timeout: got %0b want 0", timed_out); end
        n_cmp++; if (beats !== 256) begin n_bad++; $display("FAIL bp_beats: got %0d want 256", beats); end
        n_cmp++; if (bad_beats !== 0) begin n_bad++; $display("FAIL bp_order_data: got %0d bad beats want 0", bad_beats); end
        n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL bp_done_count: got %0d want 1", dones); end
    endtask

    task automatic test_latency3_stall();
        int c, beats3, bad3, e3;
        bit fin, saw_done;
        load_scramble();
        @(negedge clk) begin start3 = 1'b1; out_ready3 = 1'b0; end
        @(negedge clk) start3 = 1'b0;
        repeat (49) @(negedge clk);
        // Reads 0..3 fill the FIFO and the pipe, so the next address is held at 4.
        n_cmp++; if (addr3 !== 8'd4) begin n_bad++; $display("FAIL l3_issued: got next addr %0d want 4", addr3); end
        n_cmp++; if (valid3 !== 1'b1) begin n_bad++; $display("FAIL l3_head_valid: got %0b want 1", valid3); end
        n_cmp++; if (idx3 !== 8'd0) begin n_bad++; $display("FAIL l3_head_index: got %0d want 0", idx3); end
        beats3 = 0; bad3 = 0; e3 = 0; fin = 0; saw_done = 0; c = 0;
        while (!fin) begin
            @(negedge clk);
            out_ready3 = 1'b1;
            if (valid3) begin
                if (idx3 !== 8'(e3) || data3 !== smem[e3 & 255]) bad3++;
                beats3++;
                e3++;
            end
            if (done3) begin
                saw_done = 1;
                fin = 1;
            end
            c++;
            if (c >= 4000) fin = 1;
        end
        out_ready3 = 1'b0;
        @(negedge clk);
        n_cmp++; if (saw_done !== 1'b1) begin n_bad++; $display("FAIL l3_done: got %0b want 1", saw_done); end
        n_cmp++; if (beats3 !== 256) begin n_bad++; $display("FAIL l3_beats: got %0d want 256", beats3); end
        n_cmp++; if (bad3 !== 0) begin n_bad++; $display("FAIL l3_data: got %0d bad beats want 0", bad3); end
    endtask

    task automatic test_abort_restart();
        load_scramble();
        run1(100, -1, 100, 2000);
        n_cmp++; if (beats !== 100) begin n_bad++; $display("FAIL ab_reach: got %0d beats want 100", beats); end
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ab_busy: got %0b want 0", busy); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ab_valid: got %0b want 0", out_valid); end
        n_cmp++; if (mem_address !== 8'd0) begin n_bad++; $display("FAIL ab_addr: got %0d want 0", mem_address); end
        n_cmp++; if (out_index !== 8'd0) begin n_bad++; $display("FAIL ab_index: got %0d want 0", out_index); end
        n_cmp++; if (out_data !== 8'd0) begin n_bad++; $display("FAIL ab_data: got %0d want 0", out_data); end
        @(negedge clk) reset_n = 1'b1;
        @(negedge clk);
        run1(100, -1, -1, 2000);
        n_cmp++; if (beats !== 256) begin n_bad++; $display("FAIL ab_beats: got %0d want 256", beats); end
        n_cmp++; if (bad_beats !== 0) begin n_bad++; $display("FAIL ab_data2: got %0d bad beats want 0", bad_beats); end
        n_cmp++; if (first_c !== 3) begin n_bad++; $display("FAIL ab_latency: got %0d want 3", first_c); end
        n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL ab_done_count: got %0d want 1", dones); end
    endtask

    task automatic test_start_while_busy();
        int hi;
        load_identity();
        run1(100, 50, -1, 2000);
        n_cmp++; if (beats !== 256) begin n_bad++; $display("FAIL sb_beats: got %0d want 256", beats); end
        n_cmp++; if (bad_beats !== 0) begin n_bad++; $display("FAIL sb_data: got %0d bad beats want 0", bad_beats); end
        n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL sb_done_count: got %0d want 1", dones); end
        hi = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy || out_valid || done) hi++;
        end
        n_cmp++; if (hi !== 0) begin n_bad++; $display("FAIL sb_idle_after: got %0d active cycles want 0", hi); end
    endtask

    task automatic test_perm_check();
        load_identity();
        run1(100, -1, -1, 2000);
`ifdef PERM_CHECK_EN
        n_cmp++; if (perm_ok !== 1'b1) begin n_bad++; $display("FAIL perm_identity: got %0b want 1", perm_ok); end
        smem[7] = 8'd9;
        smem[8] = 8'd9;
        run1(100, -1, -1, 2000);
        n_cmp++; if (perm_ok !== 1'b0) begin n_bad++; $display("FAIL perm_dup: got %0b want 0", perm_ok); end
`else
        n_cmp++; if (perm_ok !== 1'b0) begin n_bad++; $display("FAIL perm_tied: got %0b want 0", perm_ok); end
`endif
        n_cmp++; if (beats !== 256) begin n_bad++; $display("FAIL perm_beats: got %0d want 256", beats); end
    endtask

    initial begin
        test_reset();
        test_identity_stream();
        test_random_backpressure();
        test_latency3_stall();
        test_abort_restart();
        test_start_while_busy();
        test_perm_check();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
